// File: rtl/tcam_arbiter_if.sv
// ---------------------------------------------------------------------------
// tcam_arbiter_if
// Bundles every bus between the arbiter and its neighbours:
//   r0_* / r1_*  : two request channels (valid/ready, op, addr, data)
//   rsp_*        : response channel back to the requesters (valid/ready)
//   t_*          : TCAM write/search ports and the TCAM search result
// Modports:
//   slave  : the arbiter side (tcam_arbiter)
//   master : the environment side (requesters, response consumer, TCAM)
// ---------------------------------------------------------------------------
interface tcam_arbiter_if;
  logic        r0_valid;
  logic        r0_ready;
  logic        r0_op;
  logic [3:0]  r0_addr;
  logic [15:0] r0_data;

  logic        r1_valid;
  logic        r1_ready;
  logic        r1_op;
  logic [3:0]  r1_addr;
  logic [15:0] r1_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_op;
  logic        rsp_found;
  logic [3:0]  rsp_addr;
  logic [15:0] rsp_data;

  logic        t_we;
  logic [3:0]  t_waddr;
  logic [15:0] t_data;
  logic        t_search;
  logic        t_found;
  logic [3:0]  t_saddr;
  logic [15:0] t_sdata;

  modport slave (
    input  r0_valid, r0_op, r0_addr, r0_data,
    output r0_ready,
    input  r1_valid, r1_op, r1_addr, r1_data,
    output r1_ready,
    output rsp_valid, rsp_id, rsp_op, rsp_found, rsp_addr, rsp_data,
    input  rsp_ready,
    output t_we, t_waddr, t_data, t_search,
    input  t_found, t_saddr, t_sdata
  );

  modport master (
    output r0_valid, r0_op, r0_addr, r0_data,
    input  r0_ready,
    output r1_valid, r1_op, r1_addr, r1_data,
    input  r1_ready,
    input  rsp_valid, rsp_id, rsp_op, rsp_found, rsp_addr, rsp_data,
    output rsp_ready,
    input  t_we, t_waddr, t_data, t_search,
    output t_found, t_saddr, t_sdata
  );
endinterface

// File: rtl/tcam_arbiter.sv
// ---------------------------------------------------------------------------
// tcam_arbiter
// Arbitrates two requesters onto a single TCAM and returns one response per
// accepted request. A request is either a write (addr/data into the TCAM) or
// a search (data is the key). Only one request is in flight at a time.
//   clk   : single clock, rising edge
//   rst   : synchronous, active-high reset
//   bus   : tcam_arbiter_if.slave (request, response and TCAM ports)
//   busy  : high whenever the FSM is not idle
// Parameter RR_EN: 1 = round-robin on contention, 0 = requester 0 always wins.
// ---------------------------------------------------------------------------
module tcam_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  tcam_arbiter_if.slave  bus,
  output logic           busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_SEARCH,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // Requester granted by the most recent accept; drives round-robin.
  logic        last_id;

  // Request latched on the accept edge.
  logic        lat_id;
  logic        lat_op;
  logic [3:0]  lat_addr;
  logic [15:0] lat_data;

  // Response payload, stable through RESP.
  logic        found_q;
  logic [3:0]  addr_q;
  logic [15:0] data_q;

  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic        acc_op;
  logic [3:0]  acc_addr;
  logic [15:0] acc_data;

  // Grant: r1 wins when alone, or on contention when round-robin says it is
  // r1's turn (r0 was granted last). r0 wins every other valid case.
  always_comb begin
    gnt1     = bus.r1_valid && (!bus.r0_valid || (RR_EN && !last_id));
    gnt0     = bus.r0_valid && !gnt1;
    acc_op   = gnt1 ? bus.r1_op   : bus.r0_op;
    acc_addr = gnt1 ? bus.r1_addr : bus.r0_addr;
    acc_data = gnt1 ? bus.r1_data : bus.r0_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    state_nxt    = state;
    accept       = 1'b0;
    bus.r0_ready = 1'b0;
    bus.r1_ready = 1'b0;
    bus.t_we     = 1'b0;
    bus.t_search = 1'b0;
    bus.t_waddr  = '0;
    bus.t_data   = '0;
    case (state)
      S_IDLE: begin
        bus.r0_ready = gnt0;
        bus.r1_ready = gnt1;
        accept       = gnt0 || gnt1;
        if (accept) begin
          if (acc_op) state_nxt = S_WRITE;
          else        state_nxt = S_SEARCH;
        end
      end
      S_WRITE: begin
        bus.t_we    = 1'b1;
        bus.t_waddr = lat_addr;
        bus.t_data  = lat_data;
        state_nxt   = S_RESP;
      end
      S_SEARCH: begin
        bus.t_search = 1'b1;
        bus.t_data   = lat_data;
        state_nxt    = S_CAPTURE;
      end
      S_CAPTURE: begin
        // Key stays on the bus while the TCAM result is sampled.
        bus.t_search = 1'b1;
        bus.t_data   = lat_data;
        state_nxt    = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched request and response registers are reset too, so
      // rsp_* read as zero after reset rather than holding stale data.
      last_id  <= 1'b1;
      lat_id   <= 1'b0;
      lat_op   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      found_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values regardless of statement order.
      if (accept) begin
        last_id  <= gnt1;
        lat_id   <= gnt1;
        lat_op   <= acc_op;
        lat_addr <= acc_addr;
        lat_data <= acc_data;
      end
      if (state == S_WRITE) begin
        found_q <= 1'b0;
        addr_q  <= lat_addr;
        data_q  <= lat_data;
      end
      if (state == S_CAPTURE) begin
        // On a miss the TCAM address/data ports are don't-care; report zeros.
        found_q <= bus.t_found;
        addr_q  <= bus.t_found ? bus.t_saddr : 4'h0;
        data_q  <= bus.t_found ? bus.t_sdata : 16'h0000;
      end
    end
  end

  assign bus.rsp_valid = (state == S_RESP);
  assign bus.rsp_id    = lat_id;
  assign bus.rsp_op    = lat_op;
  assign bus.rsp_found = found_q;
  assign bus.rsp_addr  = addr_q;
  assign bus.rsp_data  = data_q;
  assign busy          = (state != S_IDLE);

endmodule

// File: doc/tcam_arbiter.md
TCAM_ARBITER -- requirements
Module: tcam_arbiter

Interface
REQ-001 Parameter: RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 wins.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 r0_valid / r1_valid  input  1 each  request pending on requester 0 / 1.
REQ-005 r0_ready / r1_ready  output  1 each  request accepted this cycle.
REQ-006 r0_op / r1_op  input  1 each  0 = search, 1 = write.
REQ-007 r0_addr / r1_addr  input  4 each  write address; ignored for search.
REQ-008 r0_data / r1_data  input  16 each  write data or search key.
REQ-009 rsp_valid  output  1  response held for the requester.
REQ-010 rsp_ready  input  1  response consumer ready.
REQ-011 rsp_id  output  1  requester that owns the response.
REQ-012 rsp_op  output  1  op of the completed request.
REQ-013 rsp_found / rsp_addr / rsp_data  output  1/4/16  search result.
REQ-014 t_we / t_waddr / t_data / t_search  output  1/4/16/1  drive the TCAM write/search ports.
REQ-015 t_found / t_saddr / t_sdata  input  1/4/16  TCAM match flag, lowest matching index, matching entry.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, WRITE, SEARCH, CAPTURE, RESP; one transition per clock at most.
REQ-018 IDLE: rx_ready = 1 only for the granted requester while its rx_valid = 1, combinationally; the accept edge (valid & ready) latches op/addr/data/id and moves to WRITE (op = 1) or SEARCH (op = 0).
REQ-019 Grant with RR_EN = 1: a single valid requester wins; with both valid, the requester not granted last time wins; last_id updates on every accept.
REQ-020 Grant with RR_EN = 0: requester 0 wins whenever r0_valid = 1.
REQ-021 WRITE, one cycle: t_we = 1, t_waddr / t_data = latched addr / data, t_search = 0; then RESP with rsp_found = 0, rsp_addr = latched addr, rsp_data = latched data.
REQ-022 SEARCH, one cycle: t_search = 1, t_data = latched key, t_we = 0; then CAPTURE.
REQ-023 CAPTURE, one cycle: t_search = 1 and t_data held.
  - Samples t_found.
  - t_found = 1: registers t_saddr / t_sdata into rsp_addr / rsp_data.
  - t_found = 0: rsp_addr = 0, rsp_data = 0; TCAM address/data inputs are never registered.
  - Then RESP.
REQ-024 RESP: rsp_valid = 1; rsp_* stable until rsp_ready = 1; the cycle with rsp_valid & rsp_ready returns to IDLE.
REQ-025 Back-to-back: a new request is accepted no earlier than the IDLE cycle following the response handshake.
REQ-026 Latency, accept edge = cycle 0: write gives rsp_valid in cycle 2; search gives rsp_valid in cycle 3; each cycle of rsp_ready low adds one cycle.
REQ-027 Outside WRITE/SEARCH/CAPTURE: t_we = 0, t_search = 0, t_waddr = 0, t_data = 0.
REQ-028 t_we and t_search are never high in the same cycle.
REQ-029 rx_valid inputs are ignored outside IDLE; both rx_ready = 0 outside IDLE.
REQ-030 A requester dropping valid in IDLE before acceptance is not granted and does not update last_id.

Reset
REQ-031 rst = 1 at a rising edge:
  - state goes to IDLE; last_id = 1, so requester 0 wins the first contention.
  - rsp_valid = 0; rsp_id, rsp_op, rsp_found, rsp_addr, rsp_data = 0.
  - all t_* outputs = 0; busy = 0.
REQ-032 Reset mid-operation (any non-IDLE state) abandons the in-flight request: no response is produced and no further TCAM write is issued.

Verification
REQ-033 Write then search, r0 only: r0 writes addr 3, data 0xBEEF -> t_we = 1 in cycle 1, rsp_valid in cycle 2 with rsp_op = 1. Then r0 searches key 0xBEEF -> rsp_found = 1, rsp_addr = 3, rsp_data = 0xBEEF, rsp_valid 3 cycles after accept.
REQ-034 Search miss after reset (TCAM cleared to 0): search key 0x1234 -> rsp_found = 0, rsp_addr = 0, rsp_data = 0.
REQ-035 Contention, RR_EN = 1: both valid continuously with searches -> grants r0, r1, r0, r1; rsp_id follows that order. With RR_EN = 0 -> always r0.
REQ-036 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_* unchanged, busy = 1, both rx_ready = 0; the response completes on the first rsp_ready = 1 cycle.
REQ-037 Reset in CAPTURE: rst = 1 for one cycle -> next cycle IDLE, rsp_valid = 0, t_search = 0, last_id = 1.
REQ-038 Multiple matches: write key 0x00FF to addresses 5 and 9, search 0x00FF -> rsp_addr = 5.
